mux81_rr_arbiter: RTL

Round-robin arbiter that shares the 8-bit `mux81` datapath among eight requesters. It owns the `mux81` select: it picks one requester, holds the grant for a burst of up to BURST_LEN beats, and presents the selected byte to a single downstream consumer with a valid/ready handshake. It sits between the eight byte sources and the consumer of `out`.

---
 rtl/mux81_arb_pkg.sv | 32 +++
 rtl/mux81_rr_arbiter_if.sv | 24 ++
 rtl/mux81.sv | 32 +++
 rtl/mux81_rr_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mux81_arb_pkg.sv
// Shared types, sizes and the round-robin winner search for the mux81 arbiter.
package mux81_arb_pkg;

    localparam int SEL_W   = 3;
    localparam int NUM_REQ = 8;

    typedef logic arb_state_t;
    localparam arb_state_t IDLE  = 1'b0;
    localparam arb_state_t GRANT = 1'b1;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First set request strictly after ptr, wrapping so ptr itself is tried last.
    function automatic rr_pick_t rr_next(input logic [NUM_REQ-1:0] req,
                                         input logic [SEL_W-1:0]   ptr);
        rr_pick_t         pick;
        logic [SEL_W-1:0] cand;
        pick = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!pick.found && req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux81_rr_arbiter_if.sv
// Request/data/handshake bundle between the eight sources, the consumer and the arbiter.
interface mux81_rr_arbiter_if;
    import mux81_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [7:0]         in1, in2, in3, in4, in5, in6, in7, in8;
    logic               out_ready;
    logic [7:0]         out;
    logic               out_valid;
    logic               out_last;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               busy;

    modport master (
        output req, in1, in2, in3, in4, in5, in6, in7, in8, out_ready,
        input  out, out_valid, out_last, gnt, sel, busy
    );

    modport slave (
        input  req, in1, in2, in3, in4, in5, in6, in7, in8, out_ready,
        output out, out_valid, out_last, gnt, sel, busy
    );
endinterface

// File: rtl/mux81.sv
// 8:1 byte multiplexer; sel 0 picks in1 through sel 7 picking in8.
module mux81
    import mux81_arb_pkg::*;
(
    input  logic [7:0]       in1,
    input  logic [7:0]       in2,
    input  logic [7:0]       in3,
    input  logic [7:0]       in4,
    input  logic [7:0]       in5,
    input  logic [7:0]       in6,
    input  logic [7:0]       in7,
    input  logic [7:0]       in8,
    input  logic [SEL_W-1:0] sel,
    output logic [7:0]       out
);

    always_comb begin
        out = in1;
        case (sel)
            3'd0: out = in1;
            3'd1: out = in2;
            3'd2: out = in3;
            3'd3: out = in4;
            3'd4: out = in5;
            3'd5: out = in6;
            3'd6: out = in7;
            3'd7: out = in8;
            default: out = in1;
        endcase
    end

endmodule

// File: rtl/mux81_rr_arbiter.sv
// Round-robin burst arbiter driving the mux81 select toward one valid/ready consumer.
// Define MUX81_ARB_TIMEOUT_EN to revoke grants stalled for TIMEOUT cycles.
module mux81_rr_arbiter
    import mux81_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mux81_rr_arbiter_if.slave bus
);

    if (BURST_LEN < 1 || BURST_LEN > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("mux81_rr_arbiter: BURST_LEN or TIMEOUT out of range");
    end

    localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic [7:0]         mux_out;
    logic               out_valid;
    logic               beat;
    logic               last_beat;
    logic               timeout_hit;
    rr_pick_t           pick;

    assign out_valid = (state_q == GRANT) && bus.req[sel_q];
    assign beat      = out_valid && bus.out_ready;
    assign last_beat = (beat_cnt_q == LAST_CNT);
    assign pick      = rr_next(bus.req, ptr_q);

`ifdef MUX81_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_LIM = 8'(TIMEOUT - 1);

    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       stall;

    assign stall       = out_valid && !bus.out_ready;
    assign timeout_hit = stall && (stall_cnt_q == STALL_LIM);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_d != GRANT || beat) begin
            stall_cnt_d = '0;
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ptr already holds the current winner, so any exit naturally resumes the search past it.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE) begin
            if (pick.found) begin
                state_d    = GRANT;
                gnt_d      = NUM_REQ'(1) << pick.idx;
                sel_d      = pick.idx;
                ptr_d      = pick.idx;
                beat_cnt_d = '0;
            end
        end else begin
            if (!bus.req[sel_q] || (beat && last_beat) || timeout_hit) begin
                state_d = IDLE;
                gnt_d   = '0;
            end else if (beat) begin
                beat_cnt_d = beat_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            ptr_q      <= SEL_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    mux81 u_mux81 (
        .in1 (bus.in1),
        .in2 (bus.in2),
        .in3 (bus.in3),
        .in4 (bus.in4),
        .in5 (bus.in5),
        .in6 (bus.in6),
        .in7 (bus.in7),
        .in8 (bus.in8),
        .sel (sel_q),
        .out (mux_out)
    );

    assign bus.out       = out_valid ? mux_out : 8'd0;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_valid && last_beat;
    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == GRANT);

endmodule
